fwd_select_ctrl: RTL
====================

Name: fwd_select_ctrl

Overview:
- Generates the 2-bit select codes consumed by the EX-stage 3-input operand muxes: 00 = register-file value, 01 = MEM/WB write-back data, 10 = EX/MEM ALU result.
- Carries its own shadow of destination-register and control bits through the ID/EX, EX/MEM and MEM/WB stages.
- Also detects load-use hazards, asserting a stall and injecting a bubble into its ID/EX shadow.
- Sits beside the pipeline registers and drives the select_i inputs of both ALU operand muxes plus the pipeline stall control.

Parameters:
- ADDR_W, 5, register-address width.
- ZERO_GUARD, 1, when 1 a destination of register 0 never matches (no forward, no stall).

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-low.
- id_rs_i  input  ADDR_W  rs of the instruction in ID.
- id_rt_i  input  ADDR_W  rt of the instruction in ID.
- id_dst_i  input  ADDR_W  resolved destination (rd or rt) of the instruction in ID.
- id_reg_write_i  input  1  ID instruction writes the register file.
- id_mem_read_i  input  1  ID instruction is a load.
- hold_i  input  1  global freeze; all shadow stages keep their value.
- flush_i  input  1  branch taken; the instruction leaving ID becomes a bubble.
- fwd_a_o  output  2  select for the ALU operand A mux.
- fwd_b_o  output  2  select for the ALU operand B mux.
- stall_o  output  1  load-use stall; PC and IF/ID must hold.

Behaviour:
- Reset: when rst_i=0 at a clock edge, clear every shadow field (rs, rt, dst, reg_write, mem_read) in all three stages. Outputs then read fwd_a_o=00, fwd_b_o=00, stall_o=0. Reset mid-operation discards all in-flight state and takes priority over hold_i and flush_i.
- Shadow stages:
  - ID/EX holds rs, rt, dst, reg_write, mem_read.
  - EX/MEM holds dst, reg_write, mem_read.
  - MEM/WB holds dst, reg_write.
- Advance (hold_i=0): MEM/WB takes EX/MEM, and EX/MEM takes ID/EX.
- ID/EX load (hold_i=0):
  - Takes the ID inputs when stall_o=0 and flush_i=0.
  - Otherwise loads a bubble: reg_write=0, mem_read=0, rs=rt=dst=0.
- hold_i=1: no stage changes, and flush_i is ignored that cycle.
- Forward A is combinational from registered state, with zero latency relative to the ID/EX contents:
  - 10 if EX/MEM.reg_write, and EX/MEM.dst != 0 (when ZERO_GUARD), and EX/MEM.dst == ID/EX.rs.
  - else 01 if the same conditions hold for MEM/WB.
  - else 00.
  - EX/MEM has priority over MEM/WB (newest value wins).
- Forward B: identical rules using ID/EX.rt.
- Code 11 is never driven.
- A load in EX/MEM is forwarded with code 10 per the rules. The stall guarantees this never occurs for a dependent instruction.
- stall_o is combinational: 1 when all of the following hold:
  - ID/EX.mem_read=1;
  - ID/EX.dst != 0 (when ZERO_GUARD);
  - ID/EX.dst == id_rs_i, or ID/EX.dst == id_rt_i.
- stall_o is a one-cycle stall per load: after the bubble enters ID/EX, mem_read there is 0 and stall_o drops.
- stall_o is not gated by hold_i. Consumers combine the two.
- Simultaneous stall_o and flush_i: both yield the same bubble; flush semantics apply.

Test Plan:
- Reset: drive rst_i=0 for 2 cycles with arbitrary inputs -> fwd_a_o=00, fwd_b_o=00, stall_o=0; then release with id_reg_write_i=0 -> outputs stay 00/00/0.
- EX/MEM forward: issue add $3 (dst=3, rw=1), then sub with rs=3, rt=4 -> when sub is in ID/EX, fwd_a_o=10, fwd_b_o=00.
- MEM/WB forward and priority:
  - dst=5 writer, one independent instruction, then reader rs=5 -> fwd_a_o=01.
  - Two back-to-back writers to $5, then reader rt=5 -> fwd_b_o=10.
- Load-use: lw with dst=7, mem_read=1, followed by ID rs=7 -> stall_o=1 for exactly one cycle, bubble in ID/EX; next cycle reader in ID/EX gets fwd_a_o=01.
- Register 0: writer dst=0 rw=1, then reader rs=0 -> fwd_a_o=00; lw dst=0 followed by rs=0 -> stall_o=0.
- hold_i/flush_i:
  - Assert hold_i for 3 cycles mid-sequence -> fwd codes frozen.
  - flush_i with id_reg_write_i=1, dst=9, then reader rs=9 -> fwd_a_o=00.

Source files
------------

// File: rtl/fwd_select_ctrl.sv
// Operand-forwarding select and load-use stall control for the EX-stage ALU muxes.
// Keeps a private shadow of destination/control bits for ID/EX, EX/MEM and MEM/WB.
module fwd_select_ctrl #(
  parameter int ADDR_W     = 5,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic [ADDR_W-1:0] id_dst_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [1:0]        SEL_RF    = 2'b00;
  localparam logic [1:0]        SEL_WB    = 2'b01;
  localparam logic [1:0]        SEL_EX    = 2'b10;

  logic [ADDR_W-1:0] idex_rs_r;
  logic [ADDR_W-1:0] idex_rt_r;
  logic [ADDR_W-1:0] idex_dst_r;
  logic              idex_rw_r;
  logic              idex_mr_r;
  // mem_read is only consulted while the load sits in ID/EX, so later stages drop it
  logic [ADDR_W-1:0] exmem_dst_r;
  logic              exmem_rw_r;
  logic [ADDR_W-1:0] memwb_dst_r;
  logic              memwb_rw_r;

  function automatic logic dst_hit(input logic              rw,
                                   input logic [ADDR_W-1:0] dst,
                                   input logic [ADDR_W-1:0] src);
    return rw && (!ZERO_GUARD || (dst != ZERO_ADDR)) && (dst == src);
  endfunction

  // Operand A select: newest producer (EX/MEM) wins over MEM/WB
  always_comb begin
    fwd_a_o = SEL_RF;
    if (dst_hit(exmem_rw_r, exmem_dst_r, idex_rs_r)) begin
      fwd_a_o = SEL_EX;
    end else if (dst_hit(memwb_rw_r, memwb_dst_r, idex_rs_r)) begin
      fwd_a_o = SEL_WB;
    end else begin
      fwd_a_o = SEL_RF;
    end
  end

  // Operand B select, same priority as operand A
  always_comb begin
    fwd_b_o = SEL_RF;
    if (dst_hit(exmem_rw_r, exmem_dst_r, idex_rt_r)) begin
      fwd_b_o = SEL_EX;
    end else if (dst_hit(memwb_rw_r, memwb_dst_r, idex_rt_r)) begin
      fwd_b_o = SEL_WB;
    end else begin
      fwd_b_o = SEL_RF;
    end
  end

  // Load-use detection against the instruction currently in ID
  always_comb begin
    stall_o = 1'b0;
    if (idex_mr_r && (!ZERO_GUARD || (idex_dst_r != ZERO_ADDR)) &&
        ((idex_dst_r == id_rs_i) || (idex_dst_r == id_rt_i))) begin
      stall_o = 1'b1;
    end else begin
      stall_o = 1'b0;
    end
  end

  // Shadow pipeline: reset beats hold, hold beats flush/stall bubbles
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      idex_rs_r   <= ZERO_ADDR;
      idex_rt_r   <= ZERO_ADDR;
      idex_dst_r  <= ZERO_ADDR;
      idex_rw_r   <= 1'b0;
      idex_mr_r   <= 1'b0;
      exmem_dst_r <= ZERO_ADDR;
      exmem_rw_r  <= 1'b0;
      memwb_dst_r <= ZERO_ADDR;
      memwb_rw_r  <= 1'b0;
    end else if (!hold_i) begin
      memwb_dst_r <= exmem_dst_r;
      memwb_rw_r  <= exmem_rw_r;
      exmem_dst_r <= idex_dst_r;
      exmem_rw_r  <= idex_rw_r;
      if (stall_o || flush_i) begin
        idex_rs_r  <= ZERO_ADDR;
        idex_rt_r  <= ZERO_ADDR;
        idex_dst_r <= ZERO_ADDR;
        idex_rw_r  <= 1'b0;
        idex_mr_r  <= 1'b0;
      end else begin
        idex_rs_r  <= id_rs_i;
        idex_rt_r  <= id_rt_i;
        idex_dst_r <= id_dst_i;
        idex_rw_r  <= id_reg_write_i;
        idex_mr_r  <= id_mem_read_i;
      end
    end
  end

endmodule
